// File: rtl/i2c_arbiter_if.sv
// i2c_arbiter_if: requester-side handshake plus the command/response link to the shared I2C master.
// slave is the arbiter's view; master is the view of whoever drives requests and models the I2C master.
interface i2c_arbiter_if;
   localparam int unsigned ADDR_W = 7;
   localparam int unsigned DATA_W = 8;

   logic              req0;
   logic              req1;
   logic [ADDR_W-1:0] addr0;
   logic [ADDR_W-1:0] addr1;
   logic              rw0;
   logic              rw1;
   logic [DATA_W-1:0] wdata0;
   logic [DATA_W-1:0] wdata1;
   logic              gnt0;
   logic              gnt1;
   logic              done0;
   logic              done1;
   logic              err;
   logic [DATA_W-1:0] rdata;

   logic              m_enable;
   logic [ADDR_W-1:0] m_addr;
   logic              m_rw;
   logic [DATA_W-1:0] m_data_in;
   logic              m_ready;
   logic [DATA_W-1:0] m_data_out;

   modport slave (
      input  req0, req1, addr0, addr1, rw0, rw1, wdata0, wdata1, m_ready, m_data_out,
      output gnt0, gnt1, done0, done1, err, rdata, m_enable, m_addr, m_rw, m_data_in
   );

   modport master (
      output req0, req1, addr0, addr1, rw0, rw1, wdata0, wdata1, m_ready, m_data_out,
      input  gnt0, gnt1, done0, done1, err, rdata, m_enable, m_addr, m_rw, m_data_in
   );
endinterface

// File: rtl/i2c_arbiter.sv
// i2c_arbiter: round-robin sharing of one I2C master between two requesters,
// with a watchdog that aborts a transfer stuck in ISSUE or BUSY.
module i2c_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic         clk,
   input  logic         reset,
   i2c_arbiter_if.slave bus
);
   localparam int unsigned CLOG_W = $clog2(TIMEOUT_CYCLES);
   localparam int unsigned CNT_W  = (CLOG_W > 16) ? CLOG_W : 16;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DONE} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             last_grant;
   logic             win_c;
   logic             to_c;

   // Tie goes to whoever was not granted last; last_grant doubles as the current owner.
   always_comb begin
      win_c = (bus.req0 && bus.req1) ? ~last_grant : ~bus.req0;
      to_c  = (cnt == CNT_LAST);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         cnt           <= '0;
         last_grant    <= 1'b1;
         bus.gnt0      <= 1'b0;
         bus.gnt1      <= 1'b0;
         bus.done0     <= 1'b0;
         bus.done1     <= 1'b0;
         bus.err       <= 1'b0;
         bus.rdata     <= '0;
         bus.m_enable  <= 1'b0;
         bus.m_addr    <= '0;
         bus.m_rw      <= 1'b0;
         bus.m_data_in <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.m_ready && (bus.req0 || bus.req1)) begin
                  last_grant    <= win_c;
                  bus.gnt0      <= ~win_c;
                  bus.gnt1      <= win_c;
                  bus.m_addr    <= win_c ? bus.addr1 : bus.addr0;
                  bus.m_rw      <= win_c ? bus.rw1 : bus.rw0;
                  bus.m_data_in <= win_c ? bus.wdata1 : bus.wdata0;
                  bus.m_enable  <= 1'b1;
                  cnt           <= '0;
                  state         <= ISSUE;
               end
            end
            ISSUE: begin
               if (!bus.m_ready) begin
                  bus.m_enable <= 1'b0;
                  cnt          <= '0;
                  state        <= BUSY;
               end else if (to_c) begin
                  bus.m_enable <= 1'b0;
                  bus.done0    <= ~last_grant;
                  bus.done1    <= last_grant;
                  bus.err      <= 1'b1;
                  state        <= DONE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            BUSY: begin
               // A ready master wins over a coincident timeout.
               if (bus.m_ready || to_c) begin
                  bus.done0 <= ~last_grant;
                  bus.done1 <= last_grant;
                  bus.err   <= ~bus.m_ready;
                  state     <= DONE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            DONE: begin
               if (bus.m_rw && !bus.err) begin
                  bus.rdata <= bus.m_data_out;
               end
               bus.done0 <= 1'b0;
               bus.done1 <= 1'b0;
               bus.err   <= 1'b0;
               bus.gnt0  <= 1'b0;
               bus.gnt1  <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_i2c_arbiter.sv
// tb_i2c_arbiter: directed scenarios plus randomized traffic against a transaction-level
// reference model; a second instance with a short watchdog exercises the timeout path.
module tb_i2c_arbiter;
   localparam int unsigned TO_MAIN  = 1024;
   localparam int unsigned TO_SHORT = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;

   i2c_arbiter_if bus ();
   i2c_arbiter_if bus_t ();

   i2c_arbiter #(.TIMEOUT_CYCLES(TO_MAIN))  dut   (.clk(clk), .reset(rst), .bus(bus));
   i2c_arbiter #(.TIMEOUT_CYCLES(TO_SHORT)) dut_t (.clk(clk), .reset(rst), .bus(bus_t));

   always #5 clk = ~clk;

   assign bus_t.m_ready    = 1'b1;
   assign bus_t.m_data_out = 8'hEE;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] pack_dut();
      return {2'b00, bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.err, bus.m_enable,
              bus.m_addr, bus.m_rw, bus.m_data_in, bus.rdata};
   endfunction

   // Reference model: who owns the master, whether the command is still being offered,
   // and whether this is the completion cycle.
   int         own      = -1;
   bit         offering = 1'b0;
   bit         fin      = 1'b0;
   bit         fin_err  = 1'b0;
   bit         last     = 1'b1;
   int         age      = 0;
   logic [6:0] x_addr   = '0;
   logic       x_rw     = 1'b0;
   logic [7:0] x_wdata  = '0;
   logic [7:0] x_rdata  = '0;

   function automatic logic [31:0] pack_model();
      return {2'b00, own == 0, own == 1, fin && own == 0, fin && own == 1, fin_err, offering,
              x_addr, x_rw, x_wdata, x_rdata};
   endfunction

   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         own = -1; offering = 1'b0; fin = 1'b0; fin_err = 1'b0; last = 1'b1; age = 0;
         x_addr = '0; x_rw = 1'b0; x_wdata = '0; x_rdata = '0;
      end else if (fin) begin
         if (x_rw && !fin_err) x_rdata = bus.m_data_out;
         own = -1; fin = 1'b0; fin_err = 1'b0;
      end else if (own < 0) begin
         if (bus.m_ready && (bus.req0 || bus.req1)) begin
            if (bus.req0 && bus.req1) own = last ? 0 : 1;
            else                      own = bus.req0 ? 0 : 1;
            last     = (own == 1);
            x_addr   = (own == 1) ? bus.addr1  : bus.addr0;
            x_rw     = (own == 1) ? bus.rw1    : bus.rw0;
            x_wdata  = (own == 1) ? bus.wdata1 : bus.wdata0;
            offering = 1'b1;
            age      = 0;
         end
      end else if (offering ? !bus.m_ready : bus.m_ready) begin
         if (offering) begin
            offering = 1'b0;
            age      = 0;
         end else begin
            fin = 1'b1;
         end
      end else if (age == int'(TO_MAIN) - 1) begin
         offering = 1'b0;
         fin      = 1'b1;
         fin_err  = 1'b1;
      end else begin
         age++;
      end
   end

   initial forever begin
      @(negedge clk);
      chk("cycle", pack_dut(), pack_model());
      chk("one_gnt", 32'(bus.gnt0 & bus.gnt1), 32'd0);
      chk("one_done", 32'(bus.done0 & bus.done1), 32'd0);
   end

   // I2C master model: drops m_ready some cycles after m_enable, holds it low, then returns data.
   int         m_phase     = 0;
   int         m_cnt       = 0;
   int         drop_dly    = 3;
   int         low_len     = 40;
   logic [7:0] next_data   = 8'h00;
   bit         hold_low    = 1'b0;
   bit         rand_idle   = 1'b0;
   bit         rand_master = 1'b0;

   initial begin
      bus.m_ready    = 1'b1;
      bus.m_data_out = 8'h00;
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            bus.m_ready = 1'b1;
            m_phase     = 0;
         end else begin
            case (m_phase)
               0: begin
                  if (bus.m_enable) begin
                     m_cnt   = rand_master ? int'($urandom_range(0, 3)) : drop_dly - 1;
                     m_phase = 1;
                  end else if (hold_low) begin
                     bus.m_ready = 1'b0;
                  end else if (rand_idle && $urandom_range(0, 9) == 0) begin
                     bus.m_ready = 1'b0;
                     m_cnt       = int'($urandom_range(1, 4));
                     m_phase     = 3;
                  end else begin
                     bus.m_ready = 1'b1;
                  end
               end
               1: begin
                  if (m_cnt == 0) begin
                     bus.m_ready = 1'b0;
                     m_cnt       = rand_master ? int'($urandom_range(1, 12)) : low_len;
                     m_phase     = 2;
                  end else begin
                     m_cnt--;
                  end
               end
               2: begin
                  m_cnt--;
                  if (m_cnt == 0) begin
                     bus.m_ready    = 1'b1;
                     bus.m_data_out = rand_master ? 8'($urandom) : next_data;
                     m_phase        = 0;
                  end
               end
               default: begin
                  m_cnt--;
                  if (m_cnt == 0) begin
                     bus.m_ready = 1'b1;
                     m_phase     = 0;
                  end
               end
            endcase
         end
      end
   end

   task automatic wait_done(input string name, input int bound, output int who, output bit e);
      who = -1;
      e   = 1'b0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (bus.done0 || bus.done1) begin
            who = bus.done1 ? 1 : 0;
            e   = bus.err;
            return;
         end
      end
      checks++;
      errors++;
      $display("FAIL %s: no done within %0d cycles", name, bound);
   endtask

   task automatic step_req(input logic g, input logic d, inout logic r, inout logic [6:0] a,
                           inout logic rw, inout logic [7:0] wd);
      if (d) begin
         r = 1'b0;
      end else if (!r && !g) begin
         if ($urandom_range(0, 2) == 0) begin
            r = 1'b1; a = 7'($urandom); rw = 1'($urandom); wd = 8'($urandom);
         end
      end else if (g) begin
         if ($urandom_range(0, 3) == 0) begin
            a = 7'($urandom); rw = 1'($urandom); wd = 8'($urandom);
         end
         if ($urandom_range(0, 15) == 0) r = 1'b0;
      end
   endtask

   initial begin
      int who;
      bit e;
      int en_cycles;
      bit seen;
      int n_xfer;

      bus.req0 = 1'b0; bus.req1 = 1'b0; bus.addr0 = '0; bus.addr1 = '0;
      bus.rw0 = 1'b0; bus.rw1 = 1'b0; bus.wdata0 = '0; bus.wdata1 = '0;
      bus_t.req0 = 1'b0; bus_t.req1 = 1'b0; bus_t.addr0 = '0; bus_t.addr1 = '0;
      bus_t.rw0 = 1'b0; bus_t.rw1 = 1'b0; bus_t.wdata0 = '0; bus_t.wdata1 = '0;

      repeat (3) @(negedge clk);
      chk("reset_outputs", pack_dut(), 32'd0);
      rst = 1'b0;

      // Single write, requester inputs disturbed mid-transfer.
      @(posedge clk); #1;
      drop_dly = 3; low_len = 40; next_data = 8'h77;
      bus.req0 = 1'b1; bus.addr0 = 7'h50; bus.rw0 = 1'b0; bus.wdata0 = 8'hA5;
      @(negedge clk);
      chk("wr_pre_grant", 32'(bus.gnt0), 32'd0);
      @(negedge clk);
      chk("wr_grant", 32'({bus.gnt0, bus.gnt1, bus.m_enable}), 32'b101);
      bus.addr0 = 7'h11; bus.wdata0 = 8'h00;
      wait_done("wr_done", 200, who, e);
      chk("wr_who", 32'(who), 32'd0);
      chk("wr_err", 32'(e), 32'd0);
      chk("wr_addr", 32'(bus.m_addr), 32'h50);
      chk("wr_data", 32'(bus.m_data_in), 32'hA5);
      bus.req0 = 1'b0;
      @(negedge clk);
      chk("wr_single_done", 32'({bus.done0, bus.done1, bus.gnt0}), 32'd0);
      chk("wr_rdata", 32'(bus.rdata), 32'd0);

      // Single read.
      @(posedge clk); #1;
      drop_dly = 2; low_len = 5; next_data = 8'h3C;
      bus.req1 = 1'b1; bus.addr1 = 7'h1E; bus.rw1 = 1'b1; bus.wdata1 = 8'h00;
      wait_done("rd_done", 100, who, e);
      chk("rd_who", 32'(who), 32'd1);
      chk("rd_cmd", 32'({bus.err, bus.m_addr, bus.m_rw}), 32'({1'b0, 7'h1E, 1'b1}));
      chk("rd_rdata_hold", 32'(bus.rdata), 32'd0);
      bus.req1 = 1'b0;
      @(negedge clk);
      chk("rd_rdata", 32'(bus.rdata), 32'h3C);

      // Contention from reset alternates 0,1,0,1.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      drop_dly = 1; low_len = 2;
      @(posedge clk); #1;
      bus.req0 = 1'b1; bus.addr0 = 7'h01; bus.rw0 = 1'b0; bus.wdata0 = 8'h10;
      bus.req1 = 1'b1; bus.addr1 = 7'h02; bus.rw1 = 1'b0; bus.wdata1 = 8'h20;
      for (int k = 0; k < 4; k++) begin
         wait_done("rr_done", 100, who, e);
         chk($sformatf("rr_order%0d", k), 32'(who), 32'(k % 2));
      end
      bus.req0 = 1'b0; bus.req1 = 1'b0;

      // Master not ready when the request arrives.
      @(negedge clk);
      hold_low = 1'b1;
      repeat (2) @(negedge clk);
      @(posedge clk); #1;
      bus.req0 = 1'b1; bus.addr0 = 7'h2A; bus.rw0 = 1'b0; bus.wdata0 = 8'h5A;
      repeat (3) @(negedge clk);
      chk("nordy_nogrant", 32'(bus.gnt0), 32'd0);
      hold_low = 1'b0;
      @(negedge clk);
      chk("nordy_still_none", 32'(bus.gnt0), 32'd0);
      @(negedge clk);
      chk("nordy_grant", 32'(bus.gnt0), 32'd1);
      wait_done("nordy_done", 100, who, e);
      chk("nordy_who", 32'(who), 32'd0);
      bus.req0 = 1'b0;

      // Reset while the master is busy.
      @(negedge clk);
      drop_dly = 1; low_len = 50;
      @(posedge clk); #1;
      bus.req0 = 1'b1; bus.addr0 = 7'h33; bus.rw0 = 1'b1; bus.wdata0 = 8'h44;
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.gnt0 && !bus.m_enable) begin
            seen = 1'b1;
            break;
         end
      end
      chk("busy_reached", 32'(seen), 32'd1);
      repeat (3) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("rst_mid_busy", pack_dut(), 32'd0);
      @(negedge clk);
      chk("rst_no_done", 32'({bus.done0, bus.done1, bus.err}), 32'd0);
      low_len = 4;
      rst = 1'b0;
      wait_done("post_rst_done", 100, who, e);
      chk("post_rst_who", 32'({who[1:0], e}), 32'd0);
      bus.req0 = 1'b0;

      // Watchdog on the short-timeout instance, master stuck ready.
      @(posedge clk); #1;
      bus_t.req0 = 1'b1; bus_t.addr0 = 7'h10; bus_t.rw0 = 1'b1; bus_t.wdata0 = 8'h01;
      en_cycles = 0;
      seen      = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus_t.m_enable) en_cycles++;
         if (bus_t.done0 || bus_t.done1) begin
            seen = 1'b1;
            chk("to_pulse", 32'({bus_t.done0, bus_t.done1, bus_t.err, bus_t.m_enable}), 32'b1010);
            bus_t.req0 = 1'b0;
            break;
         end
      end
      chk("to_seen", 32'(seen), 32'd1);
      chk("to_enable_cycles", 32'(en_cycles), 32'(TO_SHORT));
      @(negedge clk);
      chk("to_idle", 32'({bus_t.gnt0, bus_t.gnt1, bus_t.done0, bus_t.err, bus_t.m_enable}), 32'd0);
      chk("to_rdata", 32'(bus_t.rdata), 32'd0);

      // Randomized traffic.
      rand_master = 1'b1;
      rand_idle   = 1'b1;
      n_xfer      = 0;
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         if (bus.done0 || bus.done1) n_xfer++;
         step_req(bus.gnt0, bus.done0, bus.req0, bus.addr0, bus.rw0, bus.wdata0);
         step_req(bus.gnt1, bus.done1, bus.req1, bus.addr1, bus.rw1, bus.wdata1);
      end
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      repeat (100) @(negedge clk);
      chk("rand_traffic", 32'(n_xfer > 50), 32'd1);
      chk("rand_drained", 32'({bus.gnt0, bus.gnt1}), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/i2c_arbiter.md
I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the maximum clk cycles allowed in ISSUE or in BUSY before the transfer aborts.
REQ-002 The block SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-004 The block SHALL have ports req0, req1  input  1 each  requester transaction request, level, held until done.
REQ-005 The block SHALL have ports addr0, addr1  input  7 each  requester 7-bit target address.
REQ-006 The block SHALL have ports rw0, rw1  input  1 each  requester direction, 1=read, 0=write.
REQ-007 The block SHALL have ports wdata0, wdata1  input  8 each  requester write byte.
REQ-008 The block SHALL have ports gnt0, gnt1  output  1 each  requester owns the I2C master.
REQ-009 The block SHALL have ports done0, done1  output  1 each  one-cycle completion pulse.
REQ-010 The block SHALL have port err  output  1  one-cycle pulse, coincident with done, on timeout.
REQ-011 The block SHALL have port rdata  output  8  read byte of the last completed read.
REQ-012 The block SHALL have ports m_enable  output  1, m_addr  output  7, m_rw  output  1, m_data_in  output  8  to the I2C master.
REQ-013 The block SHALL have ports m_ready  input  1 and m_data_out  input  8  from the I2C master.

Function
REQ-014 The FSM SHALL have states IDLE, ISSUE, BUSY and DONE.
REQ-015 In IDLE with m_ready=1 and any req high, the block SHALL select a winner, set its gnt, latch its addr/rw/wdata into m_addr/m_rw/m_data_in, and enter ISSUE on the next edge.
REQ-016 Arbitration SHALL be round-robin: a single requester wins outright; when both request, the requester not granted last wins; last_grant SHALL update only at grant.
REQ-017 In IDLE with m_ready=0, no grant SHALL be issued.
REQ-018 ISSUE SHALL hold m_enable=1 until m_ready is sampled 0, then clear m_enable and enter BUSY.
REQ-019 BUSY SHALL wait for m_ready=1, then enter DONE.
REQ-020 DONE SHALL last one cycle: done of the granted requester =1, rdata <= m_data_out if the latched rw=1 (rdata unchanged for writes), gnt cleared, next state IDLE.
REQ-021 A new grant SHALL be possible no earlier than the cycle after DONE; back-to-back requests SHALL therefore have at least one IDLE cycle between them.
REQ-022 m_addr, m_rw and m_data_in SHALL stay stable from grant through DONE, regardless of requester input changes.
REQ-023 Deassertion of req after grant SHALL NOT abort the transfer.
REQ-024 A 16-bit-minimum cycle counter SHALL clear on entry to ISSUE and to BUSY; when it reaches TIMEOUT_CYCLES-1 without the exit condition, the FSM SHALL enter DONE with err=1, m_enable=0, and rdata unchanged.
REQ-025 gnt0 and gnt1 SHALL never be high simultaneously; done0 and done1 SHALL never be high simultaneously.

Reset
REQ-026 On reset assertion, outputs SHALL asynchronously become: gnt*, done*, err, m_enable = 0; m_addr, m_rw, m_data_in, rdata = 0; state = IDLE; counter = 0; last_grant = 1, so requester 0 wins the first tie.
REQ-027 Reset asserted mid-transfer SHALL abort without any done or err pulse; the master is reset by the same signal.

Verification
REQ-028 Single write: req0=1, addr0=7'h50, rw0=0, wdata0=8'hA5, with a master model dropping m_ready 3 cycles after m_enable and raising it 40 cycles later -> gnt0=1, m_addr=50, m_data_in=A5, one done0 pulse, err=0, rdata unchanged.
REQ-029 Single read: req1, addr1=7'h1E, rw1=1, master returns m_data_out=8'h3C -> done1 pulse and rdata=3C in the cycle after done1.
REQ-030 Contention: req0 and req1 high together from reset -> order 0,1,0,1 over four transfers, and never both gnt high.
REQ-031 Timeout: with TIMEOUT_CYCLES=16 and m_ready stuck at 1 -> m_enable high exactly 16 cycles, then done0 and err pulse together, FSM back in IDLE.
REQ-032 Reset mid-BUSY -> all outputs 0 immediately, no done; the next req0 is granted normally.
REQ-033 m_ready=0 at request time -> no grant until m_ready=1, then grant on the following edge.
